flash_program_engine: RTL and testbench

Flash-side command sequencer that sits directly downstream of the ROM-socket command decoder. It accepts one byte-program or sector-erase request per transaction and issues the full JEDEC unlock/command write sequence to the 39SF-class parallel flash, each write with timed CE/WE strobes. It then polls DQ6 toggle status until the operation completes, DQ5 reports failure, or a timeout expires. While the engine is busy it owns the flash bus; the decoder drives the bus only while `busy` is low.

---
 rtl/flash_program_engine.sv | 132 +++++++++++++
 tb/tb_flash_program_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/flash_program_engine.sv
// flash_program_engine: JEDEC program/erase write sequencer with DQ6 toggle-bit polling
// for 39SF-class parallel flash; owns the flash bus while busy.
module flash_program_engine #(
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int READ_CYCLES = 3,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        fast_clock,
  input  logic        _reset,
  input  logic        req,
  input  logic        cmd,
  input  logic [18:0] req_address,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status,
  output logic        _ce_flash,
  output logic        _oe_flash,
  output logic        _we_flash,
  output logic [18:0] baddress,
  inout  wire  [7:0]  bdata
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, W_GAP, R_PULSE, R_GAP, FINISH} state_t;
  state_t state, state_n;
  logic [15:0] cnt, lim;
  logic [2:0] step, step_n;
  logic [TIMEOUT_BITS-1:0] poll;
  logic [18:0] addr_l, addr_e;
  logic [7:0] data_l, data_e, dout, step_data;
  logic [14:0] step_addr;
  logic cmd_l, cmd_e, accept, last, last_step, nxt_last, nxt_alt;
  logic first, extra, ref6, drive, fin_err, wr_n;
  assign accept = state == IDLE && req;
  assign cmd_e = accept ? cmd : cmd_l;
  assign addr_e = accept ? req_address : addr_l;
  assign data_e = accept ? req_data : data_l;
  assign lim = state == W_SETUP ? 16'(SETUP_CYCLES - 1) :
               state == W_PULSE ? 16'(WE_CYCLES - 1) :
               state == W_HOLD  ? 16'(HOLD_CYCLES - 1) :
               state == R_PULSE ? 16'(READ_CYCLES - 1) : 16'd0;
  assign last = cnt == lim;
  assign last_step = step == (cmd_l ? 3'd5 : 3'd3);
  // The bus is registered from the next step, so the table is indexed by step_n
  assign nxt_last = step_n == (cmd_e ? 3'd5 : 3'd3);
  assign nxt_alt = step_n == 3'd1 || step_n == 3'd4;
  assign step_addr = nxt_last ? addr_e[14:0] : nxt_alt ? 15'h2AAA : 15'h5555;
  assign step_data = nxt_last ? (cmd_e ? 8'h30 : data_e) : nxt_alt ? 8'h55 :
                     step_n == 3'd2 ? (cmd_e ? 8'h80 : 8'hA0) : 8'hAA;
  assign wr_n = state_n inside {W_SETUP, W_PULSE, W_HOLD};
  assign bdata = drive ? dout : 8'bz;

  always_comb begin
    state_n = state;
    step_n = step;
    fin_err = 1'b0;
    case (state)
      IDLE:    if (req) begin state_n = W_SETUP; step_n = 3'd0; end
      W_SETUP: if (last) state_n = W_PULSE;
      W_PULSE: if (last) state_n = W_HOLD;
      W_HOLD:  if (last) state_n = W_GAP;
      W_GAP:   begin state_n = last_step ? R_PULSE : W_SETUP; step_n = step + 3'd1; end
      R_PULSE: if (last) state_n = R_GAP;
      R_GAP:   begin
        // A still-toggling DQ6 at completion means the DQ5 retry or the timeout failed
        state_n = (!first && (status[6] == ref6 || extra || &poll)) ? FINISH : R_PULSE;
        fin_err = status[6] != ref6;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge fast_clock) begin
    if (!_reset) begin
      state <= IDLE;
      cnt <= '0;
      step <= '0;
      poll <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      status <= '0;
      _ce_flash <= 1'b1;
      _oe_flash <= 1'b1;
      _we_flash <= 1'b1;
      baddress <= '0;
      drive <= 1'b0;
      dout <= '0;
      cmd_l <= 1'b0;
      addr_l <= '0;
      data_l <= '0;
      first <= 1'b0;
      extra <= 1'b0;
      ref6 <= 1'b0;
    end else begin
      state <= state_n;
      step <= step_n;
      cnt <= state_n == state ? cnt + 16'd1 : 16'd0;
      busy <= state_n != IDLE && state_n != FINISH;
      done <= state_n == FINISH;
      _ce_flash <= !(wr_n || state_n == R_PULSE);
      _we_flash <= state_n != W_PULSE;
      _oe_flash <= state_n != R_PULSE;
      drive <= wr_n;
      if (wr_n) begin
        baddress <= {addr_e[18:15], step_addr};
        dout <= step_data;
      end else if (state_n == R_PULSE) baddress <= addr_e;
      if (accept) begin
        cmd_l <= cmd;
        addr_l <= req_address;
        data_l <= req_data;
        error <= 1'b0;
        poll <= '0;
        first <= 1'b1;
        extra <= 1'b0;
      end
      if (state == R_PULSE && last) begin
        status <= bdata;
        poll <= poll + 1'b1;
      end
      if (state == R_GAP) begin
        ref6 <= status[6];
        first <= 1'b0;
        if (!first && status[6] != ref6 && status[5]) extra <= 1'b1;
      end
      if (state_n == FINISH) error <= fin_err;
    end
  end
endmodule

// File: tb/tb_flash_program_engine.sv
// tb_flash_program_engine: scoreboard bench with a DQ6 toggle-bit flash model; expected
// writes and completions are queued by the driver and consumed by a negedge monitor.
module tb_flash_program_engine;
  logic fast_clock = 1'b0, _reset = 1'b0, req = 1'b0, cmd = 1'b0;
  logic [18:0] req_address = '0;
  logic [7:0] req_data = '0;
  logic busy, done, error, _ce_flash, _oe_flash, _we_flash;
  logic [7:0] status;
  logic [18:0] baddress;
  wire [7:0] bdata;
  int checks = 0, errors = 0, nd = 0;
  int tgl = 1000;
  logic dq5_en = 1'b0;
  int rd_n = 0, bcyc = 0, wlen = 0, dn_cnt = 0, overlap = 0;
  logic pwe = 1'b1, poe = 1'b1, pbusy = 1'b0;
  logic [18:0] cap_a = '0;
  logic [7:0] cap_d = '0;
  typedef struct {logic [18:0] a; logic [7:0] d; int w;} wr_t;
  typedef struct {logic err; logic [7:0] st; int rd; int bc;} dn_t;
  wr_t wq[$];
  dn_t dq[$];

  flash_program_engine #(.TIMEOUT_BITS(4)) dut (
    .fast_clock(fast_clock), ._reset(_reset), .req(req), .cmd(cmd),
    .req_address(req_address), .req_data(req_data), .busy(busy), .done(done),
    .error(error), .status(status), ._ce_flash(_ce_flash), ._oe_flash(_oe_flash),
    ._we_flash(_we_flash), .baddress(baddress), .bdata(bdata)
  );

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bdata[i]);
  end

  // Read k (1-based) toggles DQ6 until read t, which repeats read t-1
  function automatic logic dq6f(int k, int t);
    return k < t ? k % 2 == 1 : (t - 1) % 2 == 1;
  endfunction
  assign bdata = !_oe_flash ? {1'b0, dq6f(rd_n, tgl), dq5_en, 5'b00011} : 8'bz;

  always #5 fast_clock = ~fast_clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge fast_clock) begin
    wr_t w;
    dn_t e;
    if (busy && !pbusy) begin rd_n = 0; bcyc = 0; end
    if (busy) bcyc++;
    if (!_oe_flash && poe) rd_n++;
    if (!_oe_flash && !_we_flash) overlap++;
    if (!_we_flash) begin
      if (pwe) begin cap_a = baddress; cap_d = bdata; wlen = 0; end
      wlen++;
    end else if (!pwe) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0h data %0h", cap_a, cap_d);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", cap_a, w.a);
        chk("wr_data", cap_d, w.d);
        chk("we_width", wlen, w.w);
      end
    end
    if (done) begin
      dn_cnt++;
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: error %0b status %0h", error, status);
      end else begin
        e = dq.pop_front();
        chk("error", error, e.err);
        chk("status", status, e.st);
        chk("reads", rd_n, e.rd);
        chk("busy_cycles", bcyc, e.bc);
        chk("busy_at_done", busy, 0);
        chk("we_oe_overlap", overlap, 0);
      end
    end
    pwe = _we_flash; poe = _oe_flash; pbusy = busy;
  end

  task automatic push_wr(logic [18:0] a, logic [7:0] d, int w);
    wr_t x;
    x.a = a; x.d = d; x.w = w;
    wq.push_back(x);
  endtask

  task automatic issue(logic c, logic [18:0] a, logic [7:0] d, int t, logic d5);
    tgl = t; dq5_en = d5;
    @(posedge fast_clock); #1;
    req = 1'b1; cmd = c; req_address = a; req_data = d;
    @(posedge fast_clock); #1;
    req = 1'b0; cmd = ~c; req_address = ~a; req_data = ~d;
    chk("busy_after_accept", busy, 1);
    chk("ce_after_accept", _ce_flash, 0);
    chk("error_cleared", error, 0);
  endtask

  task automatic start(logic c, logic [18:0] a, logic [7:0] d, int t, logic d5,
                       logic err, logic [7:0] st, int rd, int bc);
    dn_t x;
    push_wr({a[18:15], 15'h5555}, 8'hAA, 4);
    push_wr({a[18:15], 15'h2AAA}, 8'h55, 4);
    push_wr({a[18:15], 15'h5555}, c ? 8'h80 : 8'hA0, 4);
    if (c) begin
      push_wr({a[18:15], 15'h5555}, 8'hAA, 4);
      push_wr({a[18:15], 15'h2AAA}, 8'h55, 4);
    end
    push_wr(a, c ? 8'h30 : d, 4);
    x.err = err; x.st = st; x.rd = rd; x.bc = bc;
    dq.push_back(x);
    nd++;
    issue(c, a, d, t, d5);
  endtask

  task automatic wait_done();
    int c = 0;
    while (dn_cnt < nd && c < 400) begin @(posedge fast_clock); c++; end
    if (dn_cnt < nd) begin
      checks++; errors++;
      $display("FAIL done_timeout: done count %0d expected %0d", dn_cnt, nd);
    end
    repeat (3) @(posedge fast_clock);
  endtask

  initial begin
    repeat (3) @(posedge fast_clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_status", status, 8'h00);
    chk("rst_ce", _ce_flash, 1);
    chk("rst_oe", _oe_flash, 1);
    chk("rst_we", _we_flash, 1);
    chk("rst_baddress", baddress, 19'h0);
    chk("rst_bdata_released", bdata, 8'hFF);
    _reset = 1'b1;
    start(1'b0, 19'h12345, 8'hA5, 4, 1'b0, 1'b0, 8'h43, 4, 44);
    wait_done();
    start(1'b1, 19'h7F000, 8'h00, 2, 1'b0, 1'b0, 8'h43, 2, 50);
    wait_done();
    start(1'b0, 19'h00ABC, 8'h3C, 2, 1'b0, 1'b0, 8'h43, 2, 36);
    repeat (10) @(posedge fast_clock);
    #1 req = 1'b1; cmd = 1'b1; req_address = 19'h7FFFF; req_data = 8'h99;
    @(posedge fast_clock); #1 req = 1'b0;
    repeat (20) @(posedge fast_clock);
    #1 req = 1'b1; cmd = 1'b0; req_address = 19'h00001;
    @(posedge fast_clock); #1 req = 1'b0;
    wait_done();
    chk("single_done", dn_cnt, nd);
    start(1'b0, 19'h00010, 8'h01, 1000, 1'b0, 1'b1, 8'h43, 15, 88);
    wait_done();
    repeat (5) @(posedge fast_clock);
    #1 chk("error_sticky", error, 1);
    start(1'b1, 19'h40000, 8'h00, 1000, 1'b1, 1'b1, 8'h63, 3, 54);
    wait_done();
    start(1'b0, 19'h2468A, 8'h5A, 3, 1'b1, 1'b0, 8'h23, 3, 40);
    wait_done();
    push_wr({4'h3, 15'h5555}, 8'hAA, 3);
    issue(1'b0, 19'h1C000, 8'h77, 4, 1'b0);
    repeat (3) @(posedge fast_clock);
    #1 _reset = 1'b0;
    @(posedge fast_clock);
    #1;
    chk("abort_we", _we_flash, 1);
    chk("abort_ce", _ce_flash, 1);
    chk("abort_oe", _oe_flash, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bdata_released", bdata, 8'hFF);
    repeat (2) @(posedge fast_clock);
    #1 _reset = 1'b1;
    repeat (10) @(posedge fast_clock);
    chk("no_done_after_abort", dn_cnt, nd);
    start(1'b0, 19'h55555, 8'hFF, 4, 1'b0, 1'b0, 8'h43, 4, 44);
    wait_done();
    chk("wr_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
